// File: rtl/tjmono_pkg.sv
// Shared types and field widths for the TJ-Monopix style hit transmitter.
package tjmono_pkg;

  localparam int COL_W             = 6;
  localparam int ROW_W             = 9;
  localparam int TS_W              = 6;
  localparam int WORD_BITS_DEFAULT = COL_W + ROW_W + 2 * TS_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FROZEN = 2'd1,
    LOAD   = 2'd2,
    SHIFT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [TS_W-1:0]  le;
    logic [TS_W-1:0]  te;
  } hit_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; rdata shows the head word combinationally.
// Push is ignored when full, pop is ignored when empty.
module sync_fifo_fwft #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 27
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tjmono_hit_tx.sv
// Hit buffer plus freeze/read serialiser: words are sent MSB first, 2 cycles after an accepted READ.
// HIT_READY drops while the FIFO is full; READs outside FROZEN (or with nothing frozen) are counted and ignored.
module tjmono_hit_tx
  import tjmono_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int WORD_BITS  = WORD_BITS_DEFAULT
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [WORD_BITS-1:0]          HIT_DATA,
  input  logic                          HIT_VALID,
  output logic                          HIT_READY,
  input  logic                          FREEZE,
  input  logic                          READ,
  output logic                          TOKEN,
  output logic                          DATA_OUT,
  output logic [7:0]                    READ_ERR_CNT,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(WORD_BITS);

  state_t               state_q, state_d;
  logic                 freeze_q;
  logic [CW-1:0]        frozen_cnt_q, frozen_cnt_d;
  logic [WORD_BITS-1:0] sr_q, sr_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]           err_q, err_d;
  logic                 token_q, token_d;
  logic                 hit_ready_q, hit_ready_d;

  logic                 push, pop, full, empty, latch, read_ok;
  logic [WORD_BITS-1:0] rdata;
  logic [CW-1:0]        count_nxt;

  sync_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_BITS)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (HIT_DATA),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (FIFO_COUNT)
  );

  assign push  = HIT_VALID & hit_ready_q;
  assign pop   = (state_q == LOAD);
  // freeze_q tracks FREEZE even in reset so a level held across reset release is not an edge.
  assign latch = (state_q == IDLE) & FREEZE & ~freeze_q;

  // Ready is registered from the next occupancy, so it always equals !full of the current cycle.
  assign count_nxt   = FIFO_COUNT + CW'(push & ~full) - CW'(pop & ~empty);
  assign hit_ready_d = (count_nxt != CW'(FIFO_DEPTH));

  always_comb begin
    state_d      = state_q;
    frozen_cnt_d = frozen_cnt_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    read_ok      = 1'b0;
    case (state_q)
      IDLE: begin
        if (latch) begin
          state_d      = FROZEN;
          frozen_cnt_d = FIFO_COUNT;
        end
      end
      FROZEN: begin
        if (!FREEZE) begin
          state_d = IDLE;
        end else if (READ && frozen_cnt_q != '0) begin
          read_ok = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sr_d         = rdata;
        frozen_cnt_d = frozen_cnt_q - 1'b1;
        bit_cnt_d    = '0;
        state_d      = SHIFT;
      end
      SHIFT: begin
        sr_d = sr_q << 1;
        if (bit_cnt_q == BW'(WORD_BITS - 1)) state_d = FREEZE ? FROZEN : IDLE;
        else                                 bit_cnt_d = bit_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    err_d = err_q;
    if (READ && !read_ok && err_q != 8'hFF) err_d = err_q + 1'b1;

    token_d = FREEZE ? ((latch ? FIFO_COUNT : frozen_cnt_q) != '0) : ~empty;
  end

  always_ff @(posedge CLK) begin
    freeze_q <= FREEZE;
    if (RST) begin
      state_q      <= IDLE;
      frozen_cnt_q <= '0;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      err_q        <= '0;
      token_q      <= 1'b0;
      hit_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frozen_cnt_q <= frozen_cnt_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      err_q        <= err_d;
      token_q      <= token_d;
      hit_ready_q  <= hit_ready_d;
    end
  end

  assign HIT_READY    = hit_ready_q;
  assign TOKEN        = token_q;
  assign READ_ERR_CNT = err_q;
  assign DATA_OUT     = (state_q == SHIFT) & sr_q[WORD_BITS-1];

endmodule

// File: tb/tb_tjmono_hit_tx.sv
// Scoreboard bench for tjmono_hit_tx: queue-based FIFO/freeze model, serial monitor keyed on expected start cycle.
module tb_tjmono_hit_tx;

  localparam int DEPTH = 16;
  localparam int WB    = 27;

  logic          CLK, RST, HIT_VALID, FREEZE, READ;
  logic [WB-1:0] HIT_DATA;
  logic          HIT_READY, TOKEN, DATA_OUT;
  logic [7:0]    READ_ERR_CNT;
  logic [4:0]    FIFO_COUNT;

  tjmono_hit_tx #(.FIFO_DEPTH(DEPTH), .WORD_BITS(WB)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .HIT_DATA     (HIT_DATA),
    .HIT_VALID    (HIT_VALID),
    .HIT_READY    (HIT_READY),
    .FREEZE       (FREEZE),
    .READ         (READ),
    .TOKEN        (TOKEN),
    .DATA_OUT     (DATA_OUT),
    .READ_ERR_CNT (READ_ERR_CNT),
    .FIFO_COUNT   (FIFO_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [WB-1:0] w;
    int            start;
  } exp_t;

  exp_t          sb[$];
  logic [WB-1:0] fifo_m[$];
  int            frozen_m, err_m;
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  bit            mon_en = 1'b0;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial monitor: a word is captured starting at the cycle the stimulus predicted.
  logic [WB-1:0] cap;
  int            nb = 0;
  bit            capturing = 1'b0;
  exp_t          cur;
  always @(negedge CLK) begin
    if (mon_en) begin
      if (capturing) begin
        cap = {cap[WB-2:0], DATA_OUT};
        nb  = nb + 1;
        if (nb == WB) begin
          capturing = 1'b0;
          check("serial_word", 32'(cap), 32'(cur.w));
        end
      end else if (sb.size() > 0 && sb[0].start == cyc) begin
        cur       = sb.pop_front();
        cap       = {{(WB-1){1'b0}}, DATA_OUT};
        nb        = 1;
        capturing = 1'b1;
      end else if (DATA_OUT !== 1'b0) begin
        miscompares = miscompares + 1;
        $display("FAIL data_out_idle: got %b expected 0 (cycle %0d)", DATA_OUT, cyc);
      end
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic push_word(input logic [WB-1:0] w);
    check("hit_ready_push", 32'(HIT_READY), 32'(fifo_m.size() < DEPTH));
    HIT_DATA  = w;
    HIT_VALID = 1'b1;
    tick(1);
    HIT_VALID = 1'b0;
    fifo_m.push_back(w);
  endtask

  task automatic raise_freeze();
    FREEZE   = 1'b1;
    frozen_m = fifo_m.size();
    tick(1);
  endtask

  // Caller guarantees the machine sits in FROZEN; returns in the LOAD cycle.
  task automatic do_read(output int c);
    exp_t e;
    READ = 1'b1;
    c    = cyc;
    if (frozen_m > 0) begin
      e.w     = fifo_m.pop_front();
      e.start = c + 2;
      sb.push_back(e);
      frozen_m = frozen_m - 1;
    end else begin
      err_m = sat(err_m);
    end
    tick(1);
    READ = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(2);
    check("rst_hit_ready", 32'(HIT_READY), 0);
    check("rst_token", 32'(TOKEN), 0);
    check("rst_data_out", 32'(DATA_OUT), 0);
    check("rst_fifo_count", 32'(FIFO_COUNT), 0);
    check("rst_err_cnt", 32'(READ_ERR_CNT), 0);
    fifo_m.delete();
    frozen_m = 0;
    err_m    = 0;
    RST      = 1'b0;
    check("hit_ready_at_release", 32'(HIT_READY), 0);
    tick(1);
    check("hit_ready_after_release", 32'(HIT_READY), 1);
  endtask

  int            c, n, nr;
  logic [WB-1:0] w, w2;

  initial begin
    RST = 1'b1; HIT_VALID = 1'b0; HIT_DATA = '0; FREEZE = 1'b0; READ = 1'b0;
    tick(1);

    // FREEZE high across reset release: no edge, READ is ignored.
    FREEZE = 1'b1;
    do_reset();
    mon_en = 1'b1;
    push_word(27'h1234567);
    push_word(27'h7654321);
    tick(2);
    check("token_freeze_over_reset", 32'(TOKEN), 0);
    READ = 1'b1; err_m = sat(err_m); tick(1); READ = 1'b0;
    tick(30);
    check("err_freeze_over_reset", 32'(READ_ERR_CNT), 32'(err_m));
    FREEZE = 1'b0;
    tick(3);

    // Three frozen words, spaced READs; TOKEN falls after the last LOAD.
    do_reset();
    push_word(27'h5A5A5A5); push_word(27'h0000001); push_word(27'h4000000);
    raise_freeze();
    tick(1);
    check("token_3_frozen", 32'(TOKEN), 1);
    do_read(c); tick(31);
    do_read(c); tick(31);
    check("token_before_3rd", 32'(TOKEN), 1);
    do_read(c); tick(3);
    check("token_after_3rd_load", 32'(TOKEN), 0);
    tick(28);
    FREEZE = 1'b0; tick(3);
    check("count_after_3", 32'(FIFO_COUNT), 0);

    // Word pushed after the freeze edge is held back until the next freeze.
    push_word(27'h1111111); push_word(27'h2222222);
    raise_freeze();
    push_word(27'h3333333);
    do_read(c); tick(31);
    do_read(c); tick(31);
    do_read(c); tick(31);
    check("token_late_word_hidden", 32'(TOKEN), 0);
    check("err_late_word", 32'(READ_ERR_CNT), 32'(err_m));
    FREEZE = 1'b0; tick(2);
    check("token_after_unfreeze", 32'(TOKEN), 1);
    check("count_late_word", 32'(FIFO_COUNT), 1);

    // Full FIFO: 17th word waits for the first pop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_word(WB'($urandom));
    check("count_full", 32'(FIFO_COUNT), DEPTH);
    check("hit_ready_full", 32'(HIT_READY), 0);
    w = WB'($urandom); HIT_DATA = w; HIT_VALID = 1'b1;
    tick(3);
    check("hit_ready_held_full", 32'(HIT_READY), 0);
    check("count_held_full", 32'(FIFO_COUNT), DEPTH);
    raise_freeze();
    do_read(c);
    check("hit_ready_in_load", 32'(HIT_READY), 0);
    tick(1);
    check("hit_ready_after_pop", 32'(HIT_READY), 1);
    tick(1);
    HIT_VALID = 1'b0;
    fifo_m.push_back(w);
    check("count_after_17th", 32'(FIFO_COUNT), DEPTH);
    tick(30);
    FREEZE = 1'b0; tick(3);

    // Randomised rounds with pushes and stray READs during shifting.
    do_reset();
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) if (fifo_m.size() < 14) push_word(WB'($urandom));
      raise_freeze();
      tick(1);
      check("token_rand_frozen", 32'(TOKEN), 32'(frozen_m != 0));
      nr = frozen_m + $urandom_range(0, 1);
      for (int k = 0; k < nr; k++) begin
        do_read(c);
        for (int i = 0; i < 30; i++) begin
          if (i >= 2 && i <= 24 && $urandom_range(0, 7) == 0) begin
            READ = 1'b1; err_m = sat(err_m);
          end
          if ($urandom_range(0, 3) == 0 && fifo_m.size() < 14) begin
            w = WB'($urandom); HIT_DATA = w; HIT_VALID = 1'b1; fifo_m.push_back(w);
          end
          tick(1);
          READ = 1'b0; HIT_VALID = 1'b0;
        end
      end
      FREEZE = 1'b0; tick(3);
      check("count_rand", 32'(FIFO_COUNT), 32'(fifo_m.size()));
      check("token_rand_idle", 32'(TOKEN), 32'(fifo_m.size() != 0));
      check("err_rand", 32'(READ_ERR_CNT), 32'(err_m));
    end

    // 300 ignored READs: 275 in IDLE, 25 during a shift; counter saturates.
    do_reset();
    READ = 1'b1;
    repeat (275) begin err_m = sat(err_m); tick(1); end
    READ = 1'b0;
    push_word(27'h6DB6DB6);
    raise_freeze();
    do_read(c);
    tick(1);
    READ = 1'b1;
    repeat (25) begin err_m = sat(err_m); tick(1); end
    READ = 1'b0;
    tick(5);
    check("err_saturated", 32'(READ_ERR_CNT), 255);
    check("err_model_255", 32'(READ_ERR_CNT), 32'(err_m));
    FREEZE = 1'b0; tick(3);

    // FREEZE drop mid-word, then reset mid-word.
    push_word(27'h2AAAAAA); push_word(27'h7FFFFFF);
    raise_freeze();
    do_read(c);
    tick(11);
    FREEZE = 1'b0;
    tick(20);
    check("token_after_drop", 32'(TOKEN), 1);
    check("count_after_drop", 32'(FIFO_COUNT), 1);
    raise_freeze();
    tick(1);
    check("token_refreeze", 32'(TOKEN), 1);
    mon_en = 1'b0;
    READ = 1'b1; w2 = fifo_m.pop_front(); tick(1); READ = 1'b0;
    tick(6);
    check("bit5_in_flight", 32'(DATA_OUT), 32'(w2[WB-1-5]));
    RST = 1'b1;
    tick(1);
    check("abort_data_out", 32'(DATA_OUT), 0);
    check("abort_fifo_count", 32'(FIFO_COUNT), 0);
    check("abort_err_cnt", 32'(READ_ERR_CNT), 0);
    check("abort_token", 32'(TOKEN), 0);
    check("abort_hit_ready", 32'(HIT_READY), 0);
    tick(2);
    RST = 1'b0; FREEZE = 1'b0;
    tick(3);

    check("scoreboard_drained", 32'(sb.size()), 0);
    check("monitor_idle", 32'(capturing), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
